// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM encoding,
// command record and FIFO depth.
package alu_cmd_sequencer_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StHold  = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] a;
    logic [1:0] b;
  } cmd_t;

  // DIV/MOD with a zero divisor: the ALU result is meaningless.
  function automatic logic is_div_by_zero(input logic [2:0] op, input logic [1:0] b);
    return ((op == OP_DIV) || (op == OP_MOD)) && (b == 2'b00);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// Two-entry registered command FIFO with full/empty flags. A push while full
// is dropped; a simultaneous push and pop keeps the count and the order.
module cmd_fifo2
  import alu_cmd_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  cmd_t       mem_q [FIFO_DEPTH];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] cnt_q;
  logic       push_ok;
  logic       pop_ok;

  assign full    = (cnt_q == 2'(FIFO_DEPTH));
  assign empty   = (cnt_q == 2'd0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Sequences buffered {op,a,b} commands through an external combinational ALU,
// registers each result and holds it until the consumer accepts it.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [1:0]       in_a,
  input  logic [1:0]       in_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       alu_a,
  output logic [1:0]       alu_b,
  input  logic [1:0]       alu_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_y,
  output logic             out_err,
  output logic [CNT_W-1:0] done_cnt
);

  state_e           state_q;
  logic [2:0]       alu_op_q;
  logic [1:0]       alu_a_q;
  logic [1:0]       alu_b_q;
  logic             out_valid_q;
  logic [1:0]       out_y_q;
  logic             out_err_q;
  logic [CNT_W-1:0] done_cnt_q;

  cmd_t push_cmd;
  cmd_t head;
  logic fifo_full;
  logic fifo_empty;
  logic pop;

  assign push_cmd = '{op: in_op, a: in_a, b: in_b};

  // Pop whenever the FSM loads a new command: from IDLE, or on a HOLD handshake.
  assign pop = !fifo_empty &&
               ((state_q == StIdle) || ((state_q == StHold) && out_ready));

  cmd_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_err   = out_err_q;
  assign done_cnt  = done_cnt_q;

  // Control FSM with registered ALU operands, result and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      alu_op_q    <= 3'b000;
      alu_a_q     <= 2'b00;
      alu_b_q     <= 2'b00;
      out_valid_q <= 1'b0;
      out_y_q     <= 2'b00;
      out_err_q   <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            alu_op_q <= head.op;
            alu_a_q  <= head.a;
            alu_b_q  <= head.b;
            state_q  <= StDrive;
          end
        end
        StDrive: begin
          if (is_div_by_zero(alu_op_q, alu_b_q)) begin
            out_y_q   <= 2'b00;
            out_err_q <= 1'b1;
          end else begin
            out_y_q   <= alu_y;
            out_err_q <= 1'b0;
          end
          out_valid_q <= 1'b1;
          state_q     <= StHold;
        end
        StHold: begin
          if (out_ready) begin
            done_cnt_q  <= done_cnt_q + CNT_W'(1);
            out_valid_q <= 1'b0;
            if (!fifo_empty) begin
              alu_op_q <= head.op;
              alu_a_q  <= head.a;
              alu_b_q  <= head.b;
              state_q  <= StDrive;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: behavioural ALU, result
// scoreboard, vector table and hand-written multi-cycle sequences.
module tb_alu_cmd_sequencer;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = 3'b000;
  logic [1:0]       in_a = 2'b00;
  logic [1:0]       in_b = 2'b00;
  logic [2:0]       alu_op;
  logic [1:0]       alu_a;
  logic [1:0]       alu_b;
  logic [1:0]       alu_y;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [1:0]       out_y;
  logic             out_err;
  logic [CNT_W-1:0] done_cnt;

  typedef struct packed {
    logic [1:0] y;
    logic       err;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] y;
    logic       err;
  } vec_t;

  exp_t exp_q[$];
  exp_t exp_head;
  vec_t tbl [10];
  int   checks = 0;
  int   failures = 0;
  int   exp_done = 0;
  int   cyc = 0;
  int   last_hs = -1;
  bit   gap_mode = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ALU; divide by zero yields junk that the sequencer must discard.
  function automatic logic [1:0] alu_f(input logic [2:0] op, input logic [1:0] a,
                                       input logic [1:0] b);
    logic [1:0] r;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: r = ~a;
      3'b011: r = a + b;
      3'b100: r = a - b;
      3'b101: r = a * b;
      3'b110: r = (b == 2'b00) ? 2'b11 : a / b;
      default: r = (b == 2'b00) ? 2'b11 : a % b;
    endcase
    return r;
  endfunction

  function automatic exp_t expect_of(input logic [2:0] op, input logic [1:0] a,
                                     input logic [1:0] b);
    exp_t e;
    if (op[2:1] == 2'b11 && b == 2'b00) begin
      e.y   = 2'b00;
      e.err = 1'b1;
    end else begin
      e.y   = alu_f(op, a, b);
      e.err = 1'b0;
    end
    return e;
  endfunction

  assign alu_y = alu_f(alu_op, alu_a, alu_b);

  alu_cmd_sequencer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_err   (out_err),
    .done_cnt  (done_cnt)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Output monitor: samples 1 time unit before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=y%0d/err%0d required=none", out_y, out_err);
      end else begin
        exp_head = exp_q.pop_front();
        check("result_y", int'(out_y), int'(exp_head.y));
        check("result_err", int'(out_err), int'(exp_head.err));
      end
      exp_done++;
      if (gap_mode && last_hs >= 0) check("handshake_gap", cyc - last_hs, 2);
      last_hs = cyc;
    end
  end

  // Caller is just after a falling edge; returns just after a falling edge.
  task automatic send(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                      input exp_t e);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_op = op;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      acc = in_ready;
      @(posedge clk);
      if (acc) exp_q.push_back(e);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n < 300) ? 1 : 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_done = 0;
    last_hs = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3'b000, 2'd3, 2'd1, 2'd1, 1'b0};  // AND
    tbl[1] = '{3'b001, 2'd2, 2'd1, 2'd3, 1'b0};  // OR
    tbl[2] = '{3'b010, 2'd1, 2'd3, 2'd2, 1'b0};  // NOT, b ignored
    tbl[3] = '{3'b011, 2'd3, 2'd2, 2'd1, 1'b0};  // ADD overflow
    tbl[4] = '{3'b100, 2'd1, 2'd2, 2'd3, 1'b0};  // SUB underflow
    tbl[5] = '{3'b101, 2'd3, 2'd3, 2'd1, 1'b0};  // MUL truncated
    tbl[6] = '{3'b110, 2'd3, 2'd2, 2'd1, 1'b0};  // DIV
    tbl[7] = '{3'b110, 2'd3, 2'd0, 2'd0, 1'b1};  // DIV by zero
    tbl[8] = '{3'b111, 2'd3, 2'd2, 2'd1, 1'b0};  // remainder
    tbl[9] = '{3'b111, 2'd2, 2'd0, 2'd0, 1'b1};  // remainder by zero

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_y", int'(out_y), 0);
    check("rst_out_err", int'(out_err), 0);
    check("rst_done_cnt", int'(done_cnt), 0);
    check("rst_alu_op", int'({alu_op, alu_a, alu_b}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", int'(in_ready), 1);

    // Latency: ADD 2+1 accepted at edge N.
    out_ready = 1'b1;
    in_op = 3'b011;
    in_a = 2'd2;
    in_b = 2'd1;
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp_t'{2'b11, 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_n_out_valid", int'(out_valid), 0);
    @(negedge clk);
    check("drive_alu_op", int'(alu_op), 3);
    check("drive_alu_a", int'(alu_a), 2);
    check("drive_alu_b", int'(alu_b), 1);
    check("drive_out_valid", int'(out_valid), 0);
    @(negedge clk);
    check("lat_n2_out_valid", int'(out_valid), 1);
    check("lat_n2_out_y", int'(out_y), 3);
    @(negedge clk);
    check("lat_done_cnt", int'(done_cnt), 1);

    // Vector table, consumer always ready.
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b, exp_t'{tbl[i].y, tbl[i].err});
    end
    drain();
    check("table_done_cnt", int'(done_cnt), 11);

    // Backpressure: two commands queued plus one held.
    out_ready = 1'b0;
    send(3'b011, 2'd1, 2'd1, expect_of(3'b011, 2'd1, 2'd1));
    send(3'b100, 2'd0, 2'd1, expect_of(3'b100, 2'd0, 2'd1));
    send(3'b001, 2'd1, 2'd2, expect_of(3'b001, 2'd1, 2'd2));
    check("bp_in_ready_low", int'(in_ready), 0);
    check("bp_out_valid", int'(out_valid), 1);
    // Command offered while full must be dropped.
    in_op = 3'b000;
    in_a = 2'd3;
    in_b = 2'd3;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("bp_hold_out_y", int'(out_y), 2);
    check("bp_in_ready_still_low", int'(in_ready), 0);
    out_ready = 1'b1;
    drain();
    check("bp_in_ready_back", int'(in_ready), 1);

    // Throughput: 4 back-to-back commands from a fresh reset.
    do_reset();
    out_ready = 1'b1;
    gap_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(3'(i + 3), 2'(i), 2'(3 - i), expect_of(3'(i + 3), 2'(i), 2'(3 - i)));
    end
    drain();
    gap_mode = 1'b0;
    check("stream_done_cnt", int'(done_cnt), 4);

    // Reset while holding a result with the FIFO full.
    out_ready = 1'b0;
    send(3'b000, 2'd3, 2'd2, expect_of(3'b000, 2'd3, 2'd2));
    send(3'b001, 2'd0, 2'd1, expect_of(3'b001, 2'd0, 2'd1));
    send(3'b011, 2'd1, 2'd2, expect_of(3'b011, 2'd1, 2'd2));
    check("pre_rst_full", int'(in_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_done = 0;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_done_cnt", int'(done_cnt), 0);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("no_stale_out_valid", int'(out_valid), 0);
    check("no_stale_done_cnt", int'(done_cnt), 0);

    // Counter wrap after 256 handshakes.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [2:0] op;
      logic [1:0] a;
      logic [1:0] b;
      op = 3'($urandom_range(0, 7));
      a = 2'($urandom_range(0, 3));
      b = 2'($urandom_range(0, 3));
      send(op, a, b, expect_of(op, a, b));
    end
    drain();
    check("wrap_handshakes", exp_done, 256);
    check("wrap_done_cnt", int'(done_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
